led_blink_ctrl: RTL and testbench

LED_BLINK_CTRL -- requirements
Module: led_blink_ctrl

---
 rtl/led_blink_pkg.sv | 20 ++
 rtl/led_blink_ch.sv | 99 +++++++++
 rtl/led_blink_ctrl.sv | 44 ++++
 tb/tb_led_blink_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_blink_pkg.sv
// Shared encodings for the LED blink controller: config modes and per-channel states.
package led_blink_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_FLASH = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_OFF   = 2'b00,
        S_ON    = 2'b01,
        S_BLINK = 2'b10,
        S_FLASH = 2'b11
    } state_e;

    localparam int unsigned PCNT_W = 4;

endpackage

// File: rtl/led_blink_ch.sv
// One LED channel: mode state machine, half-period counter and FLASH pulse counter.
module led_blink_ch
    import led_blink_pkg::*;
#(
    parameter int unsigned      CNT_W    = 25,
    parameter logic [CNT_W-1:0] HALF_DEF = CNT_W'(25'd24_999_999)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [1:0]        i_mode,
    input  logic [CNT_W-1:0]  i_half,
    input  logic [PCNT_W-1:0] i_cnt,
    output logic              o_led,
    output logic              o_busy,
    output logic              o_done
);

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_half;
    logic [PCNT_W-1:0] r_pcnt;
    logic              r_pend;
    logic              w_last;

    assign w_last = (r_cnt == r_half - 1'b1);

    // A write only latches config on its edge; r_pend applies the entry outputs one
    // edge later so every output stays a plain flop and the half-period starts clean.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_OFF;
            r_cnt   <= '0;
            r_half  <= HALF_DEF;
            r_pcnt  <= '0;
            r_pend  <= 1'b0;
            o_led   <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_we) begin
                r_half <= (i_half == '0) ? CNT_W'(1) : i_half;
                r_cnt  <= '0;
                r_pcnt <= i_cnt;
                r_pend <= 1'b1;
                unique case (mode_e'(i_mode))
                    MODE_OFF:   r_state <= S_OFF;
                    MODE_ON:    r_state <= S_ON;
                    MODE_BLINK: r_state <= S_BLINK;
                    MODE_FLASH: r_state <= S_FLASH;
                endcase
            end else if (r_pend) begin
                r_pend <= 1'b0;
                unique case (r_state)
                    S_OFF: begin
                        o_led  <= 1'b0;
                        o_busy <= 1'b0;
                    end
                    S_ON: begin
                        o_led  <= 1'b1;
                        o_busy <= 1'b0;
                    end
                    S_BLINK: begin
                        o_led  <= 1'b1;
                        o_busy <= 1'b1;
                    end
                    S_FLASH: begin
                        if (r_pcnt == '0) begin
                            r_state <= S_OFF;
                            o_led   <= 1'b0;
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                        end else begin
                            o_led  <= 1'b1;
                            o_busy <= 1'b1;
                        end
                    end
                endcase
            end else if (r_state == S_BLINK || r_state == S_FLASH) begin
                if (w_last) begin
                    r_cnt <= '0;
                    o_led <= ~o_led;
                    if (r_state == S_FLASH && o_led) begin
                        if (r_pcnt == PCNT_W'(1)) begin
                            r_state <= S_OFF;
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                        end
                        r_pcnt <= r_pcnt - 1'b1;
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/led_blink_ctrl.sv
// Multi-channel LED blink controller: decodes config writes onto independent channels.
module led_blink_ctrl
    import led_blink_pkg::*;
#(
    parameter int unsigned      CH_NUM   = 4,
    parameter int unsigned      CNT_W    = 25,
    parameter logic [CNT_W-1:0] HALF_DEF = CNT_W'(25'd24_999_999),
    localparam int unsigned     CH_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_half,
    input  logic [PCNT_W-1:0] cfg_cnt,
    output logic [CH_NUM-1:0] led_out,
    output logic [CH_NUM-1:0] busy,
    output logic [CH_NUM-1:0] done
);

    logic [CH_NUM-1:0] w_ch_we;

    // Out-of-range indices match no channel, so such writes fall through untouched.
    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        assign w_ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));

        led_blink_ch #(
            .CNT_W    (CNT_W),
            .HALF_DEF (HALF_DEF)
        ) u_ch (
            .i_clk  (sys_clk),
            .i_rst  (sys_rst),
            .i_we   (w_ch_we[i]),
            .i_mode (cfg_mode),
            .i_half (cfg_half),
            .i_cnt  (cfg_cnt),
            .o_led  (led_out[i]),
            .o_busy (busy[i]),
            .o_done (done[i])
        );
    end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed self-checking bench for led_blink_ctrl (CNT_W=8, CH_NUM=4, plus a CH_NUM=3 copy).
module tb_led_blink_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       cfg_we  = 1'b0;
    logic       cfg_we3 = 1'b0;
    logic [1:0] cfg_ch  = '0;
    logic [1:0] cfg_mode = '0;
    logic [7:0] cfg_half = '0;
    logic [3:0] cfg_cnt  = '0;
    logic [3:0] led_out, busy, done;
    logic [2:0] led3, busy3, done3;

    int total = 0;
    int bad   = 0;

    led_blink_ctrl #(.CH_NUM(4), .CNT_W(8), .HALF_DEF(8'd10)) u_dut (
        .sys_clk (sys_clk), .sys_rst (sys_rst), .cfg_we (cfg_we), .cfg_ch (cfg_ch),
        .cfg_mode (cfg_mode), .cfg_half (cfg_half), .cfg_cnt (cfg_cnt),
        .led_out (led_out), .busy (busy), .done (done)
    );

    // Three channels with a 2-bit index, so index 3 is a genuinely out-of-range write.
    led_blink_ctrl #(.CH_NUM(3), .CNT_W(8), .HALF_DEF(8'd10)) u_dut3 (
        .sys_clk (sys_clk), .sys_rst (sys_rst), .cfg_we (cfg_we3), .cfg_ch (cfg_ch),
        .cfg_mode (cfg_mode), .cfg_half (cfg_half), .cfg_cnt (cfg_cnt),
        .led_out (led3), .busy (busy3), .done (done3)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_write(input bit to3, input logic [1:0] ch, input logic [1:0] mode,
                            input logic [7:0] half, input logic [3:0] cnt);
        @(negedge sys_clk);
        cfg_ch   = ch;
        cfg_mode = mode;
        cfg_half = half;
        cfg_cnt  = cnt;
        if (to3) cfg_we3 = 1'b1;
        else     cfg_we  = 1'b1;
        @(posedge sys_clk);
        #1;
        cfg_we  = 1'b0;
        cfg_we3 = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        total++;
        if (led_out !== 4'b0000 || busy !== 4'b0000 || done !== 4'b0000) begin
            bad++;
            $display("FAIL reset_state led=%b busy=%b done=%b want 0000/0000/0000", led_out, busy, done);
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step();
            total++;
            if (led_out !== 4'b0000 || busy !== 4'b0000 || done !== 4'b0000) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d led=%b busy=%b done=%b want 0000/0000/0000",
                         k, led_out, busy, done);
            end
        end
    endtask

    task automatic test_blink();
        logic [3:0] exp_led;
        do_write(1'b0, 2'd0, 2'b10, 8'd3, 4'd0);
        total++;
        if (led_out !== 4'b0000) begin
            bad++;
            $display("FAIL blink_latency led=%b want 0000", led_out);
        end
        for (int k = 1; k <= 18; k++) begin
            step();
            exp_led = ((((k - 1) / 3) % 2) == 0) ? 4'b0001 : 4'b0000;
            total++;
            if (led_out !== exp_led || busy !== 4'b0001 || done !== 4'b0000) begin
                bad++;
                $display("FAIL blink_ch0 k=%0d led=%b busy=%b done=%b want %b/0001/0000",
                         k, led_out, busy, done, exp_led);
            end
        end
        do_write(1'b0, 2'd0, 2'b00, 8'd0, 4'd0);
        step();
        total++;
        if (led_out !== 4'b0000 || busy !== 4'b0000) begin
            bad++;
            $display("FAIL blink_off led=%b busy=%b want 0000/0000", led_out, busy);
        end
    endtask

    task automatic test_flash();
        logic [3:0] exp_led, exp_busy, exp_done;
        do_write(1'b0, 2'd2, 2'b11, 8'd2, 4'd3);
        for (int k = 1; k <= 14; k++) begin
            step();
            exp_led  = (k == 1 || k == 2 || k == 5 || k == 6 || k == 9 || k == 10) ? 4'b0100 : 4'b0000;
            exp_busy = (k <= 10) ? 4'b0100 : 4'b0000;
            exp_done = (k == 11) ? 4'b0100 : 4'b0000;
            total++;
            if (led_out !== exp_led || busy !== exp_busy || done !== exp_done) begin
                bad++;
                $display("FAIL flash_ch2 k=%0d led=%b busy=%b done=%b want %b/%b/%b",
                         k, led_out, busy, done, exp_led, exp_busy, exp_done);
            end
        end
    endtask

    task automatic test_flash_zero();
        logic [3:0] exp_done, exp_led;
        do_write(1'b0, 2'd1, 2'b11, 8'd2, 4'd0);
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) step();
            exp_done = (k == 1) ? 4'b0010 : 4'b0000;
            total++;
            if (led_out !== 4'b0000 || busy !== 4'b0000 || done !== exp_done) begin
                bad++;
                $display("FAIL flash_zero k=%0d led=%b busy=%b done=%b want 0000/0000/%b",
                         k, led_out, busy, done, exp_done);
            end
        end
        do_write(1'b0, 2'd1, 2'b10, 8'd0, 4'd0);
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_led = (k % 2 == 1) ? 4'b0010 : 4'b0000;
            total++;
            if (led_out !== exp_led || busy !== 4'b0010) begin
                bad++;
                $display("FAIL blink_half0 k=%0d led=%b busy=%b want %b/0010", k, led_out, busy, exp_led);
            end
        end
        do_write(1'b0, 2'd1, 2'b00, 8'd0, 4'd0);
        step();
    endtask

    task automatic test_abort();
        logic [3:0] exp_led;
        do_write(1'b0, 2'd3, 2'b11, 8'd2, 4'd5);
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_led = (k == 1 || k == 2 || k == 5 || k == 6) ? 4'b1000 : 4'b0000;
            total++;
            if (led_out !== exp_led || busy !== 4'b1000 || done !== 4'b0000) begin
                bad++;
                $display("FAIL abort_pre k=%0d led=%b busy=%b done=%b want %b/1000/0000",
                         k, led_out, busy, done, exp_led);
            end
        end
        do_write(1'b0, 2'd3, 2'b01, 8'd0, 4'd0);
        total++;
        if (done !== 4'b0000) begin
            bad++;
            $display("FAIL abort_edge done=%b want 0000", done);
        end
        for (int k = 1; k <= 20; k++) begin
            step();
            total++;
            if (led_out !== 4'b1000 || busy !== 4'b0000 || done !== 4'b0000) begin
                bad++;
                $display("FAIL abort_on k=%0d led=%b busy=%b done=%b want 1000/0000/0000",
                         k, led_out, busy, done);
            end
        end
        do_write(1'b0, 2'd3, 2'b00, 8'd0, 4'd0);
        step();
    endtask

    task automatic test_out_of_range();
        do_write(1'b1, 2'd2, 2'b01, 8'd0, 4'd0);
        step();
        total++;
        if (led3 !== 3'b100 || busy3 !== 3'b000) begin
            bad++;
            $display("FAIL range_valid led3=%b busy3=%b want 100/000", led3, busy3);
        end
        do_write(1'b1, 2'd3, 2'b10, 8'd1, 4'd0);
        for (int k = 1; k <= 6; k++) begin
            step();
            total++;
            if (led3 !== 3'b100 || busy3 !== 3'b000 || done3 !== 3'b000 || led_out !== 4'b0000) begin
                bad++;
                $display("FAIL range_ignore k=%0d led3=%b busy3=%b done3=%b led=%b want 100/000/000/0000",
                         k, led3, busy3, done3, led_out);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 4; c++) do_write(1'b0, 2'(c), 2'b10, 8'd3, 4'd0);
        step();
        step();
        total++;
        if (led_out !== 4'b1100 || busy !== 4'b1111) begin
            bad++;
            $display("FAIL indep_phase led=%b busy=%b want 1100/1111", led_out, busy);
        end
        #2;
        sys_rst = 1'b1;
        #1;
        total++;
        if (led_out !== 4'b0000 || busy !== 4'b0000 || done !== 4'b0000 || led3 !== 3'b000) begin
            bad++;
            $display("FAIL rst_async led=%b busy=%b done=%b led3=%b want 0000/0000/0000/000",
                     led_out, busy, done, led3);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (led_out !== 4'b0000 || done !== 4'b0000) begin
                bad++;
                $display("FAIL rst_hold k=%0d led=%b done=%b want 0000/0000", k, led_out, done);
            end
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            total++;
            if (led_out !== 4'b0000 || busy !== 4'b0000 || done !== 4'b0000) begin
                bad++;
                $display("FAIL rst_release k=%0d led=%b busy=%b done=%b want 0000/0000/0000",
                         k, led_out, busy, done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_blink();
        test_flash();
        test_flash_zero();
        test_abort();
        test_out_of_range();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200_000;
        $display("FAIL timeout bench did not finish by 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
